// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/FAULT control and IF/ID register.
// Ports: Clk_40, Reset_n_40 | Address_40 -> imem, Instruction_40 <- imem
//        Stall_40, Flush_40, BranchTaken_40, BranchTarget_40 | IFID_* , Fault_40, FetchCount_40
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 256
) (
    input  logic        Clk_40,
    input  logic        Reset_n_40,
    output logic [31:0] Address_40,
    input  logic [31:0] Instruction_40,
    input  logic        Stall_40,
    input  logic        Flush_40,
    input  logic        BranchTaken_40,
    input  logic [31:0] BranchTarget_40,
    output logic [31:0] IFID_Instruction_40,
    output logic [31:0] IFID_PCPlus4_40,
    output logic        IFID_Valid_40,
    output logic        Fault_40,
    output logic [31:0] FetchCount_40
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        adv_illegal;
    logic        tgt_illegal;

    assign Address_40  = pc;
    assign pc_plus4    = pc + 32'd4;
    // 33-bit compare so a memory filling the whole 4 GiB space stays legal
    assign adv_illegal = {1'b0, pc_plus4} >= MEM_BYTES;
    assign tgt_illegal = BranchTarget_40[1:0] != 2'b00;

    always_ff @(posedge Clk_40 or negedge Reset_n_40) begin
        if (!Reset_n_40) begin
            state               <= IDLE;
            pc                  <= RESET_PC;
            IFID_Instruction_40 <= '0;
            IFID_PCPlus4_40     <= '0;
            IFID_Valid_40       <= 1'b0;
            Fault_40            <= 1'b0;
            FetchCount_40       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state               <= RUN;
                    pc                  <= RESET_PC;
                    IFID_Instruction_40 <= '0;
                    IFID_PCPlus4_40     <= '0;
                    IFID_Valid_40       <= 1'b0;
                end
                RUN: begin
                    if (BranchTaken_40) begin
                        // wrong-path squash on every redirect
                        IFID_Instruction_40 <= '0;
                        IFID_PCPlus4_40     <= '0;
                        IFID_Valid_40       <= 1'b0;
                        if (tgt_illegal) begin
                            state    <= FAULT;
                            Fault_40 <= 1'b1;
                        end else begin
                            pc <= BranchTarget_40;
                        end
                    end else if (Stall_40) begin
                        if (Flush_40) begin
                            IFID_Instruction_40 <= '0;
                            IFID_PCPlus4_40     <= '0;
                            IFID_Valid_40       <= 1'b0;
                        end
                    end else if (adv_illegal) begin
                        state               <= FAULT;
                        Fault_40            <= 1'b1;
                        IFID_Instruction_40 <= '0;
                        IFID_PCPlus4_40     <= '0;
                        IFID_Valid_40       <= 1'b0;
                    end else begin
                        pc <= pc_plus4;
                        if (Flush_40) begin
                            IFID_Instruction_40 <= '0;
                            IFID_PCPlus4_40     <= '0;
                            IFID_Valid_40       <= 1'b0;
                        end else begin
                            IFID_Instruction_40 <= Instruction_40;
                            IFID_PCPlus4_40     <= pc_plus4;
                            IFID_Valid_40       <= 1'b1;
                            FetchCount_40       <= FetchCount_40 + 32'd1;
                        end
                    end
                end
                FAULT: begin
                    Fault_40            <= 1'b1;
                    IFID_Instruction_40 <= '0;
                    IFID_PCPlus4_40     <= '0;
                    IFID_Valid_40       <= 1'b0;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a combinational 256-word memory.
// Ports: none; drives the DUT and checks every output against hand values.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fault;
    logic [31:0] count;

    logic [31:0] mem [256];

    int n_checks;
    int n_fails;

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(256)
    ) dut (
        .Clk_40             (clk),
        .Reset_n_40         (rst_n),
        .Address_40         (addr),
        .Instruction_40     (instr),
        .Stall_40           (stall),
        .Flush_40           (flush),
        .BranchTaken_40     (br),
        .BranchTarget_40    (tgt),
        .IFID_Instruction_40(ifid_instr),
        .IFID_PCPlus4_40    (ifid_pc4),
        .IFID_Valid_40      (ifid_valid),
        .Fault_40           (fault),
        .FetchCount_40      (count)
    );

    assign instr = mem[addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a,
                           input logic [31:0] i, input logic [31:0] p4,
                           input logic v, input logic f,
                           input logic [31:0] c);
        chk({tag, ".addr"}, addr, a);
        chk({tag, ".instr"}, ifid_instr, i);
        chk({tag, ".pc4"}, ifid_pc4, p4);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
        chk({tag, ".fault"}, {31'd0, fault}, {31'd0, f});
        chk({tag, ".count"}, count, c);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020;

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        br    = 1'b0;
        tgt   = '0;
        #23;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;

        // IDLE cycle, then sequential fetch
        step();
        chk_all("idle", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        step();
        chk_all("seq1", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0, 32'd1);
        step();
        chk_all("seq2", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 1'b0, 32'd2);

        // stall three cycles at PC=8
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("stall", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 1'b0, 32'd2);
        end
        stall = 1'b0;
        step();
        chk_all("unstall", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 1'b0, 32'd3);

        // redirect beats stall
        br    = 1'b1;
        stall = 1'b1;
        tgt   = 32'h40;
        step();
        chk_all("redir", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd3);
        br    = 1'b0;
        stall = 1'b0;
        step();
        chk_all("post_redir", 32'h44, 32'hA500_0010, 32'h44, 1'b1, 1'b0, 32'd4);

        // get to PC=16 with a valid IF/ID entry
        br  = 1'b1;
        tgt = 32'h0C;
        step();
        chk_all("redir_c", 32'hC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd4);
        br = 1'b0;
        step();
        chk_all("to16", 32'h10, 32'hA500_0003, 32'h10, 1'b1, 1'b0, 32'd5);

        // flush together with stall at PC=16
        flush = 1'b1;
        stall = 1'b1;
        step();
        chk_all("flush_stall", 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
        flush = 1'b0;
        stall = 1'b0;
        step();
        chk_all("resume", 32'h14, 32'hA500_0004, 32'h14, 1'b1, 1'b0, 32'd6);

        // flush on a normal advance: PC moves, bubble loaded
        flush = 1'b1;
        step();
        chk_all("flush_adv", 32'h18, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);
        flush = 1'b0;

        // misaligned redirect target
        br  = 1'b1;
        tgt = 32'h42;
        step();
        chk_all("bad_tgt", 32'h18, 32'h0, 32'h0, 1'b0, 1'b1, 32'd6);
        for (int k = 0; k < 10; k++) begin
            br    = 1'($urandom);
            stall = 1'($urandom);
            flush = 1'($urandom);
            tgt   = $urandom & 32'h0000_03FC;
            step();
            chk_all("fault_hold", 32'h18, 32'h0, 32'h0, 1'b0, 1'b1, 32'd6);
        end

        // asynchronous reset while in FAULT
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("areset1", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        br    = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        tgt   = '0;
        #2;
        rst_n = 1'b1;
        step();
        chk_all("idle2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        // run to the top of memory
        for (int k = 0; k < 255; k++) step();
        chk_all("top", 32'h3FC, 32'hA500_00FE, 32'h3FC, 1'b1, 1'b0, 32'd255);
        step();
        chk_all("end_fault", 32'h3FC, 32'h0, 32'h0, 1'b0, 1'b1, 32'd255);

        // reset pulse mid-cycle, fetch restarts at RESET_PC
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("areset2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk_all("idle3", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        step();
        chk_all("restart", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
